sprite_motion_controller: RTL

//  Upstream stage of the frame-draw sequencer. Converts DE1 push-buttons into player state:
//  - position xSprite/ySprite and animation frame spriteId
//  - one physics/animation step per rising edge of update (the sequencer's ~10 Hz sprite-update pulse)

---
 rtl/sprite_pkg.sv | 36 +++
 rtl/sprite_motion_controller_if.sv | 25 ++
 rtl/sprite_motion_controller_key_sync_edge.sv | 36 +++
 rtl/sprite_motion_controller.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite pipeline: sprite ROM ids, screen size, key bit positions
// and the motion FSM state type.
package sprite_pkg;

  localparam logic [3:0] ID_IDLE       = 4'd0;
  localparam logic [3:0] ID_RUN0       = 4'd1;
  localparam logic [3:0] ID_RUN1       = 4'd2;
  localparam logic [3:0] ID_RUN2       = 4'd3;
  localparam logic [3:0] ID_AIR        = 4'd4;
  localparam logic [3:0] ID_FLOOR      = 4'd5;
  localparam logic [3:0] ID_BACKGROUND = 4'd15;

  localparam int SCREEN_H = 240;
  localparam int SCREEN_W = 320;

  localparam int KEY_JUMP  = 0;
  localparam int KEY_RIGHT = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_BOOST = 3;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2
  } motion_state_e;

  // Run cycle 1->2->3->1; anything else (idle, airborne) enters at the first run frame.
  function automatic logic [3:0] next_run_id(input logic [3:0] id);
    case (id)
      ID_RUN0: next_run_id = ID_RUN1;
      ID_RUN1: next_run_id = ID_RUN2;
      default: next_run_id = ID_RUN0;
    endcase
  endfunction

endpackage

// File: rtl/sprite_motion_controller_if.sv
// Step request, raw keys and player-state outputs between the sequencer and the motion controller.
// Handshake: update is a level whose rising edge requests one step; stepDone pulses for exactly
// one cycle when xSprite/ySprite/spriteId hold the new step. No back-pressure exists.
interface sprite_motion_controller_if;
  import sprite_pkg::*;

  logic          update;
  logic [3:0]    keys;
  logic [7:0]    xSprite;
  logic [8:0]    ySprite;
  logic [3:0]    spriteId;
  logic          stepDone;
  motion_state_e dbg_state;

  modport master (
    output update, keys,
    input  xSprite, ySprite, spriteId, stepDone, dbg_state
  );

  modport slave (
    input  update, keys,
    output xSprite, ySprite, spriteId, stepDone, dbg_state
  );

endinterface

// File: rtl/sprite_motion_controller_key_sync_edge.sv
// Two-flop synchroniser for one active-low push-button, plus a one-cycle press (1->0) pulse.
module key_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Released (high) is the idle value so reset never fabricates a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign level = ~sync2_q;
  assign press = prev_q & ~sync2_q;

endmodule

// File: rtl/sprite_motion_controller.sv
// Player motion: jump physics on x (height), saturating horizontal walk on y, and run/air
// animation id. One step per rising edge of update.
module sprite_motion_controller
  import sprite_pkg::*;
#(
  parameter int unsigned X_GROUND = 32,
  parameter int unsigned X_MAX    = 219,
  parameter int unsigned JUMP_VEL = 12,
  parameter int unsigned Y_MIN    = 0,
  parameter int unsigned Y_MAX    = 300,
  parameter int unsigned Y_START  = 150,
  parameter int unsigned Y_STEP   = 4
) (
  input logic                       clock,
  input logic                       reset,
  sprite_motion_controller_if.slave bus
);

  logic [3:0] key_lvl;
  logic [3:0] key_press;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_sync_edge u_key (
      .clk   (clock),
      .rst_n (reset),
      .key_n (bus.keys[i]),
      .level (key_lvl[i]),
      .press (key_press[i])
    );
  end

  logic unused_keys;
  assign unused_keys = ^{key_lvl[KEY_JUMP], key_press[KEY_BOOST], key_press[KEY_LEFT],
                         key_press[KEY_RIGHT]};

  logic          upd_q, upd_d;
  logic          step_q, step_d;
  logic          done_q, done_d;
  motion_state_e state_q, state_d;
  logic [7:0]    vel_q, vel_d;
  logic          jump_req_q, jump_req_d;
  logic [7:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [3:0]    id_q, id_d;

  logic          go_right, go_left;
  logic [8:0]    x_sum, x_launch;
  logic signed [9:0] y_delta, y_sum;

  always_comb begin
    upd_d      = bus.update;
    step_d     = bus.update & ~upd_q;
    done_d     = step_q;
    state_d    = state_q;
    vel_d      = vel_q;
    jump_req_d = jump_req_q;
    x_d        = x_q;
    y_d        = y_q;
    id_d       = id_q;

    go_right = key_lvl[KEY_RIGHT] & ~key_lvl[KEY_LEFT];
    go_left  = key_lvl[KEY_LEFT] & ~key_lvl[KEY_RIGHT];
    y_delta  = key_lvl[KEY_BOOST] ? 10'(Y_STEP * 2) : 10'(Y_STEP);
    y_sum    = {1'b0, y_q};
    if (go_right)     y_sum = {1'b0, y_q} + y_delta;
    else if (go_left) y_sum = {1'b0, y_q} - y_delta;

    x_sum    = {1'b0, x_q} + {1'b0, vel_q};
    x_launch = {1'b0, x_q} + 9'(JUMP_VEL);

    // Presses in the air are dropped rather than queued for after landing.
    if (key_press[KEY_JUMP] && state_q == ST_GROUND) jump_req_d = 1'b1;

    if (step_q) begin
      if (y_sum < $signed(10'(Y_MIN)))      y_d = 9'(Y_MIN);
      else if (y_sum > $signed(10'(Y_MAX))) y_d = 9'(Y_MAX);
      else                                  y_d = y_sum[8:0];

      case (state_q)
        ST_GROUND: begin
          if (jump_req_q) begin
            x_d        = (x_launch > 9'(X_MAX)) ? 8'(X_MAX) : x_launch[7:0];
            vel_d      = 8'(JUMP_VEL - 1);
            jump_req_d = 1'b0;
            state_d    = ST_RISE;
            id_d       = ID_AIR;
          end else if (go_right || go_left) begin
            id_d = next_run_id(id_q);
          end else begin
            id_d = ID_IDLE;
          end
        end
        ST_RISE: begin
          id_d = ID_AIR;
          if (x_sum > 9'(X_MAX)) begin
            x_d     = 8'(X_MAX);
            vel_d   = 8'd1;
            state_d = ST_FALL;
          end else begin
            x_d   = x_sum[7:0];
            vel_d = vel_q - 8'd1;
            if (vel_q == 8'd1) begin
              vel_d   = 8'd1;
              state_d = ST_FALL;
            end
          end
        end
        ST_FALL: begin
          // Compared as x <= vel + ground so the subtraction can never underflow.
          if ({1'b0, x_q} <= {1'b0, vel_q} + 9'(X_GROUND)) begin
            x_d     = 8'(X_GROUND);
            vel_d   = 8'd0;
            state_d = ST_GROUND;
            id_d    = ID_IDLE;
          end else begin
            x_d   = x_q - vel_q;
            vel_d = vel_q + 8'd1;
            id_d  = ID_AIR;
          end
        end
        default: state_d = ST_GROUND;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upd_q      <= 1'b0;
      step_q     <= 1'b0;
      done_q     <= 1'b0;
      state_q    <= ST_GROUND;
      vel_q      <= 8'd0;
      jump_req_q <= 1'b0;
      x_q        <= 8'(X_GROUND);
      y_q        <= 9'(Y_START);
      id_q       <= ID_IDLE;
    end else begin
      upd_q      <= upd_d;
      step_q     <= step_d;
      done_q     <= done_d;
      state_q    <= state_d;
      vel_q      <= vel_d;
      jump_req_q <= jump_req_d;
      x_q        <= x_d;
      y_q        <= y_d;
      id_q       <= id_d;
    end
  end

  assign bus.xSprite   = x_q;
  assign bus.ySprite   = y_q;
  assign bus.spriteId  = id_q;
  assign bus.stepDone  = done_q;
  assign bus.dbg_state = state_q;

endmodule
